keras_inference_sequencer: RTL
==============================

KERAS_INFERENCE_SEQUENCER -- requirements
Module: keras_inference_sequencer

Interface
REQ-001 SHALL have parameter IN_W, default 180, input vector width (10 x 18-bit features).
REQ-002 SHALL have parameter OUT_W, default 18, result width.
REQ-003 SHALL have parameter TIMEOUT, default 1023, maximum cycles allowed in ISSUE plus WAIT_RES.
REQ-004 SHALL have parameter CNT_W, default 16, sample counter width.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port s_data, input, IN_W, upstream sample.
REQ-008 SHALL have port s_valid, input, 1, upstream sample valid.
REQ-009 SHALL have port s_ready, output, 1, sample accepted when s_valid and s_ready are both high.
REQ-010 SHALL have port acc_in_dat, output, IN_W, drives the accelerator input_1 channel.
REQ-011 SHALL have port acc_in_vld, output, 1, accelerator input valid.
REQ-012 SHALL have port acc_in_triosy, input, 1, accelerator signals input consumed.
REQ-013 SHALL have port acc_out_dat, input, OUT_W, accelerator layer output.
REQ-014 SHALL have port acc_out_vld, input, 1, accelerator output valid.
REQ-015 SHALL have port m_data, output, OUT_W, result to downstream.
REQ-016 SHALL have port m_valid, output, 1, result valid.
REQ-017 SHALL have port m_ready, input, 1, downstream accepts the result.
REQ-018 SHALL have ports busy, output, 1 (state is not IDLE); err_timeout, output, 1; clear_err, input, 1; and sample_count, output, CNT_W.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT_RES, DRAIN, ERROR.
REQ-020 SHALL drive s_ready = (IDLE) or (DRAIN and m_ready); in ERROR, ISSUE and WAIT_RES s_ready SHALL be 0.
REQ-021 IDLE: on s_valid and s_ready, SHALL latch s_data into in_reg, clear the timer and go to ISSUE next cycle.
REQ-022 ISSUE: SHALL hold acc_in_vld=1 and acc_in_dat=in_reg, stable, until the cycle acc_in_triosy=1, then go to WAIT_RES.
REQ-023 WAIT_RES: on acc_out_vld=1, SHALL capture acc_out_dat into out_reg and go to DRAIN; acc_out_vld SHALL be ignored in every other state.
REQ-024 DRAIN: SHALL drive m_valid=1 and m_data=out_reg, holding both stable until m_ready=1.
REQ-025 DRAIN plus m_ready: SHALL increment sample_count, which wraps from 2^CNT_W-1 to 0.
REQ-026 DRAIN plus m_ready plus s_valid: SHALL latch the new sample and go directly to ISSUE, a zero-bubble back-to-back handoff; otherwise it SHALL go to IDLE.
REQ-027 Timer SHALL count every cycle in ISSUE and WAIT_RES; on reaching TIMEOUT, the FSM SHALL go to ERROR and set err_timeout=1.
REQ-028 If acc_out_vld arrives in the same cycle the timer reaches TIMEOUT, the result SHALL win: go to DRAIN, no error.
REQ-029 ERROR: acc_in_vld=0, m_valid=0; err_timeout SHALL stay 1 until clear_err=1, then go to IDLE and clear the timer; sample_count SHALL be held.
REQ-030 clear_err outside ERROR SHALL have no effect.
REQ-031 Minimum latency from s_valid acceptance to m_valid SHALL be 3 cycles (ISSUE 1, WAIT_RES 1, DRAIN).

Reset
REQ-032 rst=0 SHALL asynchronously force state IDLE and zero in_reg, out_reg, timer and sample_count.
REQ-033 During reset, outputs SHALL be: s_ready=1 after release, acc_in_vld=0, m_valid=0, busy=0, err_timeout=0, acc_in_dat=0, m_data=0.
REQ-034 Reset asserted mid-transaction SHALL abandon the sample with no result emitted; the first post-reset accept SHALL start a fresh transaction.

Structure
REQ-035 Package keras_seq_pkg SHALL hold the state enum, IN_W and OUT_W defaults and the TIMEOUT default.
REQ-036 The timeout counter SHALL be a sub-module keras_seq_timer (clear, enable, terminal-count output).

Verification
REQ-037 Single sample: accelerator returns 18'h0000F two cycles after triosy -> m_data=18'h0000F, m_valid held until m_ready, sample_count=1.
REQ-038 Back-to-back: 4 samples with s_valid and m_ready always high -> no idle cycle between the DRAIN of one sample and the ISSUE of the next; sample_count=4.
REQ-039 Backpressure: m_ready low for 20 cycles -> m_data stable, s_ready=0 throughout, no sample lost.
REQ-040 Timeout: accelerator never asserts acc_out_vld, TIMEOUT=15 -> err_timeout=1 after 15 cycles; clear_err -> IDLE, next sample completes normally.
REQ-041 Race: acc_out_vld coincides with the terminal count -> DRAIN with a valid result, err_timeout=0.
REQ-042 Reset in WAIT_RES, and sample_count at 16'hFFFF plus one more result -> all outputs reset; counter wraps to 0.

Source files
------------

// File: rtl/keras_seq_pkg.sv
// Shared definitions for the Keras inference sequencer.
// Holds the sequencer state encoding and the default widths and timeout limit
// used by the top level and by the timeout counter.
package keras_seq_pkg;

  localparam int KERAS_IN_W    = 180;   // 10 features x 18 bits
  localparam int KERAS_OUT_W   = 18;    // one 18-bit result
  localparam int KERAS_TIMEOUT = 1023;  // cycles allowed in ISSUE plus WAIT_RES
  localparam int KERAS_CNT_W   = 16;    // completed-sample counter width

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_RES = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_ERROR    = 3'd4
  } seq_state_e;

endpackage

// File: rtl/keras_seq_timer.sv
// Transaction watchdog for the inference sequencer.
// Counts enabled cycles since the last clear. tc is high during the enabled
// cycle that is the TIMEOUT-th one, so the owner can leave on that edge.
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous active-low reset
//   clear   - synchronous clear of the count (wins over enable)
//   enable  - count this cycle
//   tc      - terminal count reached in this enabled cycle
module keras_seq_timer
  import keras_seq_pkg::*;
#(
  parameter int TIMEOUT = KERAS_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST_CNT = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_r;

  assign tc = enable && (count_r == LAST_CNT);

  // Cycle counter; saturates at the terminal value because the owner leaves then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {TW{1'b0}};
    end else if (clear) begin
      count_r <= {TW{1'b0}};
    end else if (enable && !tc) begin
      count_r <= count_r + TW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/keras_inference_sequencer.sv
// Sequences one sample at a time through an HLS-generated Keras accelerator.
// A sample is accepted from the upstream valid/ready stream, presented to the
// accelerator input channel until consumed (triosy), the single result is
// captured and then offered downstream until accepted. A watchdog aborts a
// transaction that spends TIMEOUT cycles in ISSUE plus WAIT_RES.
// Ports:
//   clk, rst                  - clock, asynchronous active-low reset
//   s_data/s_valid/s_ready    - upstream sample stream
//   acc_in_dat/acc_in_vld     - accelerator input channel
//   acc_in_triosy             - accelerator consumed the input
//   acc_out_dat/acc_out_vld   - accelerator result
//   m_data/m_valid/m_ready    - downstream result stream
//   busy                      - sequencer not idle
//   err_timeout/clear_err     - sticky timeout flag and its release
//   sample_count              - completed results, wrapping
module keras_inference_sequencer
  import keras_seq_pkg::*;
#(
  parameter int IN_W    = KERAS_IN_W,
  parameter int OUT_W   = KERAS_OUT_W,
  parameter int TIMEOUT = KERAS_TIMEOUT,
  parameter int CNT_W   = KERAS_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [IN_W-1:0]  acc_in_dat,
  output logic             acc_in_vld,
  input  logic             acc_in_triosy,
  input  logic [OUT_W-1:0] acc_out_dat,
  input  logic             acc_out_vld,
  output logic [OUT_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             err_timeout,
  input  logic             clear_err,
  output logic [CNT_W-1:0] sample_count
);

  seq_state_e       state_r;
  seq_state_e       state_nxt_s;
  logic [IN_W-1:0]  in_reg_r;
  logic [OUT_W-1:0] out_reg_r;
  logic [CNT_W-1:0] cnt_r;
  logic             acc_in_vld_r;
  logic             m_valid_r;
  logic             busy_r;
  logic             err_r;

  logic load_in_s;
  logic load_out_s;
  logic cnt_inc_s;
  logic timer_clr_s;
  logic timer_en_s;
  logic timer_tc_s;
  logic s_ready_s;

  keras_seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clr_s),
    .enable (timer_en_s),
    .tc     (timer_tc_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nxt_s = state_r;
    load_in_s   = 1'b0;
    load_out_s  = 1'b0;
    cnt_inc_s   = 1'b0;
    timer_clr_s = 1'b0;
    timer_en_s  = 1'b0;
    s_ready_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        s_ready_s = 1'b1;
        if (s_valid) begin
          load_in_s   = 1'b1;
          timer_clr_s = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        timer_en_s = 1'b1;
        if (timer_tc_s) begin
          state_nxt_s = ST_ERROR;
        end else if (acc_in_triosy) begin
          state_nxt_s = ST_WAIT_RES;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT_RES: begin
        timer_en_s = 1'b1;
        // A result arriving on the terminal-count cycle still completes.
        if (acc_out_vld) begin
          load_out_s  = 1'b1;
          state_nxt_s = ST_DRAIN;
        end else if (timer_tc_s) begin
          state_nxt_s = ST_ERROR;
        end else begin
          state_nxt_s = ST_WAIT_RES;
        end
      end
      ST_DRAIN: begin
        s_ready_s = m_ready;
        if (m_ready) begin
          cnt_inc_s = 1'b1;
          // Zero-bubble handoff: the next sample is taken in the same cycle.
          if (s_valid) begin
            load_in_s   = 1'b1;
            timer_clr_s = 1'b1;
            state_nxt_s = ST_ISSUE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_ERROR: begin
        if (clear_err) begin
          timer_clr_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ERROR;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sample and result holding registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_reg_r  <= {IN_W{1'b0}};
      out_reg_r <= {OUT_W{1'b0}};
    end else begin
      if (load_in_s) begin
        in_reg_r <= s_data;
      end else begin
        in_reg_r <= in_reg_r;
      end
      if (load_out_s) begin
        out_reg_r <= acc_out_dat;
      end else begin
        out_reg_r <= out_reg_r;
      end
    end
  end

  // Completed-sample counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_inc_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Status outputs registered from the next state so they align with state_r.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_in_vld_r <= 1'b0;
      m_valid_r    <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      acc_in_vld_r <= (state_nxt_s == ST_ISSUE);
      m_valid_r    <= (state_nxt_s == ST_DRAIN);
      busy_r       <= (state_nxt_s != ST_IDLE);
      err_r        <= (state_nxt_s == ST_ERROR);
    end
  end

  assign s_ready      = s_ready_s;
  assign acc_in_dat   = in_reg_r;
  assign acc_in_vld   = acc_in_vld_r;
  assign m_data       = out_reg_r;
  assign m_valid      = m_valid_r;
  assign busy         = busy_r;
  assign err_timeout  = err_r;
  assign sample_count = cnt_r;

endmodule
